// File: rtl/template_matcher.sv
// Compares a 16x16 sample bitmap against a character template one row per cycle.
// 17 cycles from accepted start to done; start is ignored while busy.
module template_matcher #(
  parameter logic [8:0] THRESH = 9'd230
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  output logic [3:0]  tmpl_addr,
  input  logic [15:0] tmpl_row,
  output logic [3:0]  smp_addr,
  input  logic [15:0] smp_row,
  output logic        busy,
  output logic        done,
  output logic [8:0]  score,
  output logic        match
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [3:0]  row;
  logic [8:0]  acc;
  logic [4:0]  pc_q;
  logic [4:0]  pc;
  logic [8:0]  total;

  assign tmpl_addr = row;
  assign smp_addr  = row;
  assign total     = acc + {4'd0, pc_q};

  // Agreeing pixels in the currently addressed row.
  always_comb begin
    pc = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pc = pc + {4'd0, ~(tmpl_row[i] ^ smp_row[i])};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (row == 4'd15) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      row   <= 4'd0;
      acc   <= 9'd0;
      pc_q  <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      score <= 9'd0;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == FLUSH);

      if (state == SCAN) begin
        row  <= (row == 4'd15) ? 4'd0 : row + 4'd1;
        pc_q <= pc;
      end else begin
        row <= 4'd0;
      end

      // pc_q is stale on the first SCAN edge, so row 0's count joins one edge later.
      if (state == IDLE && start)
        acc <= 9'd0;
      else if (state == SCAN && row != 4'd0)
        acc <= total;

      if (state == FLUSH) begin
        score <= total;
        match <= (total >= THRESH);
      end
    end
  end

endmodule

// File: doc/template_matcher.md
TEMPLATE_MATCHER -- requirements
Module: template_matcher

Interface
REQ-001 Parameter THRESH, default 9'd230: minimum matching-pixel count for match=1.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request one 16x16 comparison; sampled on rising edge.
REQ-005 tmpl_addr  out  4  row address to the character template ROM.
REQ-006 tmpl_row  in  16  template row at tmpl_addr, combinational, same cycle; bit 0 = leftmost pixel.
REQ-007 smp_addr  out  4  row address to the captured sample bitmap.
REQ-008 smp_row  in  16  sample row at smp_addr, combinational, same cycle; same bit order.
REQ-009 busy  out  1  high while a comparison is in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 score  out  9  matching-pixel count of the last completed comparison, 0..256.
REQ-012 match  out  1  score >= THRESH for the last completed comparison.

Function
REQ-013 FSM states: IDLE, SCAN, FLUSH; all outputs registered except tmpl_addr/smp_addr, which are driven by the row counter.
REQ-014 IDLE: busy=0; row counter=0; start=1 -> SCAN, accumulator cleared.
REQ-015 SCAN: tmpl_addr=smp_addr=row counter; each cycle registers pc_q = popcount(~(tmpl_row ^ smp_row)) (0..16) and increments the row counter.
REQ-016 Accumulator (9 bits) adds pc_q on every edge after the first SCAN edge; no overflow possible (max 256).
REQ-017 SCAN with row counter=15 -> FLUSH; row counter does not wrap, returns to 0.
REQ-018 FLUSH (one cycle): score <= accumulator + pc_q; match <= (accumulator + pc_q >= THRESH); done <= 1; -> IDLE.
REQ-019 Latency: start sampled at edge E0; rows 0..15 addressed during cycles after E0..E15; done high for exactly the cycle following edge E17.
REQ-020 busy=1 from the edge that accepts start through the FLUSH cycle; deasserted together with done rising.
REQ-021 start while busy=1 (SCAN or FLUSH) is ignored, not queued.
REQ-022 start high in the cycle done is high is accepted (back-to-back); start held high continuously yields one comparison every 18 cycles.
REQ-023 score and match hold their values until the next FLUSH; they do not change at start.
REQ-024 tmpl_addr and smp_addr always carry identical values; both are 0 outside SCAN.

Reset
REQ-025 clr=1 forces immediately, independent of clk: state=IDLE, row counter=0, accumulator=0, pc_q=0, busy=0, done=0, score=0, match=0, addresses=0.
REQ-026 clr asserted mid-SCAN or in FLUSH aborts the comparison; no done pulse and no score update for it.
REQ-027 After clr deasserts, the first start sampled on a clk edge begins a normal comparison.

Verification
REQ-028 Sample rows identical to template (digit-5 bitmap, rows 0..2 = 16'hFFFF) -> score=256, match=1, done one cycle, 17 edges after start edge.
REQ-029 Sample = bitwise inverse of template in all rows -> score=0, match=0.
REQ-030 Sample differs in exactly 26 pixels spread across rows 0, 7, 15 -> score=230, match=1; 27 differing pixels -> score=229, match=0.
REQ-031 Address monitor: tmpl_addr=smp_addr step 0,1,...,15 on consecutive cycles after start, 0 otherwise; extra start pulses at rows 4 and in FLUSH -> ignored, single done.
REQ-032 start held high for 60 cycles -> done pulses exactly 18 cycles apart, busy low only during done cycles, each score correct.
REQ-033 clr pulsed (not aligned to clk) while row counter=8 -> all outputs 0 at once, no done; following start with identical bitmaps -> score=256, match=1.
